// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with bounded hold and owner encoder

// Converts the arbiter's one-hot (or all-zero) grant into the owner index.
module rr_enc4to2 (
   input  logic [3:0] onehot_i,
   output logic [1:0] idx_o
);

   // Only one-hot codes or zero arrive here; zero maps to index 0 and is
   // qualified downstream by busy.
   always_comb begin
      idx_o = 2'd0;
      case (onehot_i)
         4'b0010: idx_o = 2'd1;
         4'b0100: idx_o = 2'd2;
         4'b1000: idx_o = 2'd3;
         default: idx_o = 2'd0;
      endcase
   end

endmodule

// Round-robin arbiter: one owner at a time, held until it releases, drops its
// request, or reaches MAX_HOLD cycles; handoff to the next requester has no gap.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] req_i,
   input  logic       release_i,
   output logic [3:0] grant_o,
   output logic       busy_o,
   output logic       timeout_o,
   output logic [1:0] owner_o
);

   localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e     state_q;
   logic [1:0] ptr_q;
   logic [1:0] g_q;
   logic [7:0] cnt_q;
   logic [3:0] grant_q;
   logic       busy_q;
   logic       timeout_q;

   logic       exit_rel;
   logic       exit_drop;
   logic       exit_hold;
   logic       exit_any;
   logic       hold_only;
   logic [3:0] own_mask;
   logic [3:0] srch_vec;
   logic [1:0] srch_start;
   logic       pick_found;
   logic [1:0] pick_idx;
   logic [3:0] pick_onehot;
   logic [7:0] cnt_d;
   logic [1:0] ptr_d;

   // Exit conditions for the current owner and the rotating search that picks
   // the next owner; in GRANT the current owner is masked out so a revoked
   // owner cannot immediately win again.
   always_comb begin
      exit_rel    = release_i;
      exit_drop   = ~req_i[g_q];
      exit_hold   = (cnt_q == MaxHold);
      exit_any    = exit_rel | exit_drop | exit_hold;
      hold_only   = exit_hold & ~exit_rel & ~exit_drop;
      own_mask    = 4'b0001 << g_q;
      cnt_d       = cnt_q + 8'd1;
      ptr_d       = g_q + 2'd1;

      if (state_q == IDLE) begin
         srch_vec   = req_i;
         srch_start = ptr_q;
      end else begin
         srch_vec   = req_i & ~own_mask;
         srch_start = g_q + 2'd1;
      end

      pick_found = 1'b0;
      pick_idx   = srch_start;
      for (int k = 0; k < 4; k++) begin
         if (!pick_found && srch_vec[srch_start + 2'(k)]) begin
            pick_found = 1'b1;
            pick_idx   = srch_start + 2'(k);
         end
      end
      pick_onehot = 4'b0001 << pick_idx;
   end

   // Arbitration FSM with registered grant, busy and timeout outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         g_q       <= 2'd0;
         cnt_q     <= 8'd0;
         grant_q   <= 4'b0000;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timeout_q <= 1'b0;
               if (pick_found) begin
                  state_q <= GRANT;
                  g_q     <= pick_idx;
                  grant_q <= pick_onehot;
                  busy_q  <= 1'b1;
                  cnt_q   <= 8'd1;
               end else begin
                  grant_q <= 4'b0000;
                  busy_q  <= 1'b0;
                  cnt_q   <= 8'd0;
               end
            end
            GRANT: begin
               if (exit_any) begin
                  ptr_q     <= ptr_d;
                  timeout_q <= hold_only;
                  if (pick_found) begin
                     g_q     <= pick_idx;
                     grant_q <= pick_onehot;
                     busy_q  <= 1'b1;
                     cnt_q   <= 8'd1;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= 4'b0000;
                     busy_q  <= 1'b0;
                     cnt_q   <= 8'd0;
                  end
               end else begin
                  cnt_q     <= cnt_d;
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               grant_q   <= 4'b0000;
               busy_q    <= 1'b0;
               timeout_q <= 1'b0;
               cnt_q     <= 8'd0;
            end
         endcase
      end
   end

   assign grant_o   = grant_q;
   assign busy_o    = busy_q;
   assign timeout_o = timeout_q;

   rr_enc4to2 u_enc (
      .onehot_i (grant_q),
      .idx_o    (owner_o)
   );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4 against a behavioural model

module tb_rr_arbiter_4;

   localparam int MAXH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       rel;
   logic [3:0] grant;
   logic       busy;
   logic       timeout;
   logic [1:0] owner;

   always #5 clk = ~clk;

   rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .release_i (rel),
      .grant_o   (grant),
      .busy_o    (busy),
      .timeout_o (timeout),
      .owner_o   (owner)
   );

   typedef struct packed {
      logic [3:0] grant;
      logic       timeout;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   event chk_ev;

   // Reference model: owner number (-1 = none), cycles held, search start.
   int m_own  = -1;
   int m_hold = 0;
   int m_ptr  = 0;
   bit m_to   = 1'b0;

   function automatic int pick(bit [3:0] v, int start);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (start + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_own  = -1;
      m_hold = 0;
      m_ptr  = 0;
      m_to   = 1'b0;
   endfunction

   function automatic void model_clock();
      bit [3:0] r;
      bit       quit_rel, quit_drop, quit_lim;
      int       nxt;
      r = req;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_own < 0) begin
         m_to = 1'b0;
         nxt  = pick(r, m_ptr);
         if (nxt >= 0) begin
            m_own  = nxt;
            m_hold = 1;
         end
      end else begin
         quit_rel  = rel;
         quit_drop = !r[m_own];
         quit_lim  = (m_hold == MAXH);
         if (quit_rel || quit_drop || quit_lim) begin
            m_to  = !quit_rel && !quit_drop;
            m_ptr = (m_own + 1) % 4;
            r[m_own] = 1'b0;
            nxt = pick(r, m_ptr);
            if (nxt >= 0) begin
               m_own  = nxt;
               m_hold = 1;
            end else begin
               m_own  = -1;
               m_hold = 0;
            end
         end else begin
            m_hold = m_hold + 1;
            m_to   = 1'b0;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.grant   = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      e.timeout = m_to;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, want);
      end
   endtask

   // Monitor: pops one expectation per presented output and compares.
   initial begin
      exp_t e;
      int   want_idx;
      forever begin
         @(negedge clk or chk_ev);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("busy", 32'(busy), 32'(|e.grant));
            check("timeout", 32'(timeout), 32'(e.timeout));
            if (e.grant != 4'b0000) begin
               want_idx = 0;
               for (int i = 0; i < 4; i++) if (e.grant[i]) want_idx = i;
               check("owner_idx", 32'(owner), 32'(want_idx));
            end
         end
      end
   end

   task automatic step(input logic [3:0] r, input logic rl);
      @(posedge clk);
      model_clock();
      sb_q.push_back(model_out());
      #1;
      req = r;
      rel = rl;
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      sb_q.push_back(model_out());
      -> chk_ev;
   endtask

   task automatic steps(input logic [3:0] r, input logic rl, input int n);
      for (int i = 0; i < n; i++) step(r, rl);
   endtask

   initial begin
      logic [3:0] r;
      logic       rl;
      rst_n = 1'b1;
      req   = 4'b1111;
      rel   = 1'b0;
      #1;
      rst_n = 1'b0;
      #2;
      model_reset();
      sb_q.push_back(model_out());
      -> chk_ev;

      steps(4'b1111, 1'b0, 2);
      rst_n = 1'b1;

      steps(4'b1111, 1'b1, 6);
      steps(4'b0000, 1'b0, 2);

      steps(4'b0101, 1'b0, 20);
      steps(4'b0000, 1'b0, 2);

      steps(4'b0010, 1'b0, 22);
      steps(4'b0000, 1'b0, 2);

      steps(4'b1000, 1'b0, 3);
      steps(4'b0000, 1'b0, 1);
      steps(4'b1001, 1'b0, 3);
      steps(4'b0000, 1'b0, 2);

      steps(4'b0100, 1'b0, 3);
      async_reset();
      steps(4'b1100, 1'b0, 2);
      rst_n = 1'b1;
      steps(4'b1100, 1'b0, 4);

      r  = 4'b0000;
      rl = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         rl = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
            step(r, rl);
            rst_n = 1'b1;
         end else begin
            step(r, rl);
         end
      end

      step(4'b0000, 1'b0);
      @(negedge clk);
      #1;
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
